decode_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 65 ++++++
 rtl/decode_stage_instr_decoder.sv | 118 +++++++++++
 rtl/decode_stage.sv | 110 +++++++++++
 tb/tb_decode_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 decode types: opcodes, R-type functs, ALU operations and the
// packed control word carried through ID/EX.
package mips_pkg;

  typedef enum logic [5:0] {
    OpRtype = 6'h00,
    OpJ     = 6'h02,
    OpJal   = 6'h03,
    OpBeq   = 6'h04,
    OpBne   = 6'h05,
    OpAddiu = 6'h09,
    OpSlti  = 6'h0a,
    OpSltiu = 6'h0b,
    OpAndi  = 6'h0c,
    OpOri   = 6'h0d,
    OpXori  = 6'h0e,
    OpLui   = 6'h0f,
    OpLw    = 6'h23,
    OpSw    = 6'h2b
  } opcode_t;

  typedef enum logic [5:0] {
    FnSll  = 6'h00,
    FnSrl  = 6'h02,
    FnSra  = 6'h03,
    FnAddu = 6'h21,
    FnSubu = 6'h23,
    FnAnd  = 6'h24,
    FnOr   = 6'h25,
    FnXor  = 6'h26,
    FnNor  = 6'h27,
    FnSlt  = 6'h2a,
    FnSltu = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src_imm;
    logic is_branch;
    logic branch_ne;
    logic is_jump;
    logic illegal;
  } ctrl_t;

  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Purely combinational MIPS32 instruction decoder: register fields, immediate,
// ALU operation, control word and source-usage flags.
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  wa,
  output logic [31:0] imm,
  output logic [4:0]  shamt,
  output alu_op_t     alu_op,
  output ctrl_t       ctrl,
  output logic        uses_rs,
  output logic        uses_rt
);

  logic [31:0] sext;
  logic [31:0] zext;

  assign sext = {{16{instr[15]}}, instr[15:0]};
  assign zext = {16'h0000, instr[15:0]};

  always_comb begin
    rs      = instr[25:21];
    rt      = instr[20:16];
    shamt   = instr[10:6];
    wa      = 5'd0;
    imm     = 32'h0;
    alu_op  = AluAdd;
    ctrl    = '0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;

    case (instr[31:26])
      OpRtype: begin
        uses_rt        = 1'b1;
        wa             = instr[15:11];
        ctrl.reg_write = 1'b1;
        case (instr[5:0])
          FnAddu: alu_op = AluAdd;
          FnSubu: alu_op = AluSub;
          FnAnd:  alu_op = AluAnd;
          FnOr:   alu_op = AluOr;
          FnXor:  alu_op = AluXor;
          FnNor:  alu_op = AluNor;
          FnSlt:  alu_op = AluSlt;
          FnSltu: alu_op = AluSltu;
          FnSll:  begin alu_op = AluSll; uses_rs = 1'b0; end
          FnSrl:  begin alu_op = AluSrl; uses_rs = 1'b0; end
          FnSra:  begin alu_op = AluSra; uses_rs = 1'b0; end
          default: begin
            wa             = 5'd0;
            ctrl.reg_write = 1'b0;
            ctrl.illegal   = 1'b1;
          end
        endcase
      end
      OpAddiu, OpSlti, OpSltiu, OpLw: begin
        wa               = instr[20:16];
        imm              = sext;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        case (instr[31:26])
          OpSlti:  alu_op = AluSlt;
          OpSltiu: alu_op = AluSltu;
          OpLw:    ctrl.mem_read = 1'b1;
          default: alu_op = AluAdd;
        endcase
      end
      OpAndi, OpOri, OpXori: begin
        wa               = instr[20:16];
        imm              = zext;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        case (instr[31:26])
          OpAndi:  alu_op = AluAnd;
          OpOri:   alu_op = AluOr;
          default: alu_op = AluXor;
        endcase
      end
      OpLui: begin
        wa               = instr[20:16];
        imm              = {instr[15:0], 16'h0000};
        alu_op           = AluLui;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpSw: begin
        uses_rt          = 1'b1;
        imm              = sext;
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpBeq, OpBne: begin
        uses_rt        = 1'b1;
        imm            = {sext[29:0], 2'b00};
        alu_op         = AluSub;
        ctrl.is_branch = 1'b1;
        ctrl.branch_ne = (instr[31:26] == OpBne);
      end
      OpJ, OpJal: begin
        uses_rs      = 1'b0;
        imm          = {4'b0000, instr[25:0], 2'b00};
        ctrl.is_jump = 1'b1;
        if (instr[31:26] == OpJal) begin
          wa             = REG_RA;
          ctrl.reg_write = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // r0 is hardwired; never report a write to it.
    if (wa == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS32 ID stage: drives register-file read addresses, detects load-use
// hazards, and holds the ID/EX register behind valid/ready handshakes.
module decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_wa,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_shamt,
  output logic [3:0]       ex_alu_op,
  output logic [7:0]       ex_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_wa;
  logic [31:0] dec_imm;
  logic [4:0]  dec_shamt;
  alu_op_t     dec_alu_op;
  ctrl_t       dec_ctrl;
  logic        dec_uses_rs;
  logic        dec_uses_rt;

  instr_decoder u_decoder (
    .instr   (if_instr),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .wa      (dec_wa),
    .imm     (dec_imm),
    .shamt   (dec_shamt),
    .alu_op  (dec_alu_op),
    .ctrl    (dec_ctrl),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt)
  );

  ctrl_t ex_ctrl_s;
  logic  load_use;
  logic  hold;
  logic  load;
  logic  bubble;

  assign ex_ctrl_s = ctrl_t'(ex_ctrl);
  assign hold      = ex_valid & ~ex_ready;
  assign load_use  = ex_valid & ex_ctrl_s.mem_read & (ex_rt != 5'd0) &
                     ((dec_uses_rs & (ex_rt == dec_rs)) | (dec_uses_rt & (ex_rt == dec_rt)));
  assign id_ready  = ~flush & ~hold & ~load_use;
  assign load      = if_valid & id_ready;
  assign bubble    = if_valid & load_use & ~flush & ~hold;

  // Re-read held sources when not loading so stalled entries see late writeback.
  assign rf_raddr1 = load ? dec_rs : ex_rs;
  assign rf_raddr2 = load ? dec_rt : ex_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_pc     <= RESET_PC;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_wa     <= 5'd0;
      ex_imm    <= 32'h0;
      ex_shamt  <= 5'd0;
      ex_alu_op <= 4'd0;
      ex_ctrl   <= 8'h00;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (hold) begin
      ex_valid <= ex_valid;
    end else if (load) begin
      ex_valid  <= 1'b1;
      ex_pc     <= if_pc;
      ex_rs     <= dec_rs;
      ex_rt     <= dec_rt;
      ex_wa     <= dec_wa;
      ex_imm    <= dec_imm;
      ex_shamt  <= dec_shamt;
      ex_alu_op <= dec_alu_op;
      ex_ctrl   <= dec_ctrl;
    end else begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, load-use bubbles, stalls,
// flush priority and asynchronous reset, checked with immediate assertions.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_wa;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic [3:0]  ex_alu_op;
  logic [7:0]  ex_ctrl;
  logic [31:0] bubble_cnt;

  int checks;
  int failures;

  decode_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_wa      (ex_wa),
    .ex_imm     (ex_imm),
    .ex_shamt   (ex_shamt),
    .ex_alu_op  (ex_alu_op),
    .ex_ctrl    (ex_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an instruction mid-cycle, then let combinational outputs settle.
  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {31'h0, ex_valid}, 32'h0);
    chk("rst_pc", ex_pc, 32'h0);
    chk("rst_imm", ex_imm, 32'h0);
    chk("rst_ctrl", {24'h0, ex_ctrl}, 32'h0);
    chk("rst_wa", {27'h0, ex_wa}, 32'h0);
    chk("rst_bubbles", bubble_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDIU r8,r0,0x8000
    offer(1'b1, 32'h2408_8000, 32'h0000_0100);
    chk("addiu_ready", {31'h0, id_ready}, 32'h1);
    chk("addiu_raddr1", {27'h0, rf_raddr1}, 32'd0);
    chk("addiu_raddr2", {27'h0, rf_raddr2}, 32'd8);
    tick();
    chk("addiu_valid", {31'h0, ex_valid}, 32'h1);
    chk("addiu_imm", ex_imm, 32'hFFFF_8000);
    chk("addiu_wa", {27'h0, ex_wa}, 32'd8);
    chk("addiu_alu", {28'h0, ex_alu_op}, 32'd0);
    chk("addiu_ctrl", {24'h0, ex_ctrl}, 32'h90);
    chk("addiu_pc", ex_pc, 32'h0000_0100);

    // LW r9,4(r29) then ADDU r10,r9,r9: one bubble
    offer(1'b1, 32'h8FA9_0004, 32'h0000_0104);
    chk("lw_ready", {31'h0, id_ready}, 32'h1);
    chk("lw_raddr1", {27'h0, rf_raddr1}, 32'd29);
    tick();
    chk("lw_ctrl", {24'h0, ex_ctrl}, 32'hD0);
    chk("lw_imm", ex_imm, 32'h4);
    offer(1'b1, 32'h0129_5021, 32'h0000_0108);
    chk("lu_ready", {31'h0, id_ready}, 32'h0);
    chk("lu_raddr1_held", {27'h0, rf_raddr1}, 32'd29);
    chk("lu_raddr2_held", {27'h0, rf_raddr2}, 32'd9);
    tick();
    chk("lu_bubble_valid", {31'h0, ex_valid}, 32'h0);
    chk("lu_bubble_cnt", bubble_cnt, 32'd1);
    chk("lu_ready_after", {31'h0, id_ready}, 32'h1);
    chk("lu_raddr1_issue", {27'h0, rf_raddr1}, 32'd9);
    chk("lu_raddr2_issue", {27'h0, rf_raddr2}, 32'd9);
    tick();
    chk("addu_valid", {31'h0, ex_valid}, 32'h1);
    chk("addu_wa", {27'h0, ex_wa}, 32'd10);
    chk("addu_ctrl", {24'h0, ex_ctrl}, 32'h80);
    chk("addu_pc", ex_pc, 32'h0000_0108);

    // LW r0,0(r29) then ADDU r10,r0,r0: no hazard on r0
    offer(1'b1, 32'h8FA0_0000, 32'h0000_010C);
    tick();
    chk("lw0_ctrl", {24'h0, ex_ctrl}, 32'h50);
    offer(1'b1, 32'h0000_5021, 32'h0000_0110);
    chk("lw0_ready", {31'h0, id_ready}, 32'h1);
    tick();
    chk("lw0_valid", {31'h0, ex_valid}, 32'h1);
    chk("lw0_bubbles", bubble_cnt, 32'd1);

    // ORI r11,r1,0x00FF then stall three cycles with XORI r12,r2,0x0F0F offered
    offer(1'b1, 32'h342B_00FF, 32'h0000_0114);
    tick();
    chk("ori_alu", {28'h0, ex_alu_op}, 32'd3);
    offer(1'b1, 32'h384C_0F0F, 32'h0000_0118);
    ex_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", {31'h0, id_ready}, 32'h0);
      chk("stall_raddr1", {27'h0, rf_raddr1}, 32'd1);
      chk("stall_raddr2", {27'h0, rf_raddr2}, 32'd11);
      tick();
      chk("stall_valid", {31'h0, ex_valid}, 32'h1);
      chk("stall_imm", ex_imm, 32'h0000_00FF);
      chk("stall_wa", {27'h0, ex_wa}, 32'd11);
      chk("stall_pc", ex_pc, 32'h0000_0114);
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    chk("unstall_ready", {31'h0, id_ready}, 32'h1);
    chk("unstall_raddr1", {27'h0, rf_raddr1}, 32'd2);
    chk("unstall_raddr2", {27'h0, rf_raddr2}, 32'd12);
    tick();
    chk("xori_wa", {27'h0, ex_wa}, 32'd12);
    chk("xori_imm", ex_imm, 32'h0000_0F0F);

    // flush together with a load-use hazard
    offer(1'b1, 32'h8FA9_0004, 32'h0000_011C);
    tick();
    offer(1'b1, 32'h0129_5021, 32'h0000_0120);
    flush = 1'b1;
    #1;
    chk("flush_ready", {31'h0, id_ready}, 32'h0);
    tick();
    chk("flush_valid", {31'h0, ex_valid}, 32'h0);
    chk("flush_bubbles", bubble_cnt, 32'd1);
    chk("flush_wa_kept", {27'h0, ex_wa}, 32'd9);
    @(negedge clk);
    flush = 1'b0;

    // JAL 0x100 at 0x9000
    offer(1'b1, 32'h0C00_0100, 32'h0000_9000);
    tick();
    chk("jal_wa", {27'h0, ex_wa}, 32'd31);
    chk("jal_ctrl", {24'h0, ex_ctrl}, 32'h82);
    chk("jal_imm", ex_imm, 32'h0000_0400);
    chk("jal_pc", ex_pc, 32'h0000_9000);

    // opcode 0x3F is illegal
    offer(1'b1, 32'hFC00_0000, 32'h0000_9004);
    tick();
    chk("illegal_ctrl", {24'h0, ex_ctrl}, 32'h01);

    // BNE r1,r2,-1
    offer(1'b1, 32'h1422_FFFF, 32'h0000_9008);
    tick();
    chk("bne_imm", ex_imm, 32'hFFFF_FFFC);
    chk("bne_ctrl", {24'h0, ex_ctrl}, 32'h0C);
    chk("bne_alu", {28'h0, ex_alu_op}, 32'd1);

    // LUI r5,0x1234
    offer(1'b1, 32'h3C05_1234, 32'h0000_900C);
    tick();
    chk("lui_imm", ex_imm, 32'h1234_0000);
    chk("lui_alu", {28'h0, ex_alu_op}, 32'd11);

    // SLL r3,r4,5
    offer(1'b1, 32'h0004_1940, 32'h0000_9010);
    tick();
    chk("sll_shamt", {27'h0, ex_shamt}, 32'd5);
    chk("sll_wa", {27'h0, ex_wa}, 32'd3);
    chk("sll_alu", {28'h0, ex_alu_op}, 32'd8);
    chk("sll_rt", {27'h0, ex_rt}, 32'd4);

    // asynchronous reset mid-stream
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, ex_valid}, 32'h0);
    chk("arst_pc", ex_pc, 32'h0);
    chk("arst_bubbles", bubble_cnt, 32'h0);
    tick();
    chk("arst_hold_valid", {31'h0, ex_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_release_valid", {31'h0, ex_valid}, 32'h0);
    tick();
    chk("arst_reload_valid", {31'h0, ex_valid}, 32'h1);
    chk("arst_reload_pc", ex_pc, 32'h0000_9010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
